uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- UART transmitter, 8 data bits, no parity, 1 stop bit, LSB first, line idles high.
- Front end is a small synchronous FIFO with a valid/ready byte interface, so host-side logic can queue result bytes without waiting per byte.
- Serializer drains the FIFO back-to-back; it is the outbound counterpart of the team's UART receiver on the same serial link.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz clock at 115200 baud); legal range 4 or more.
- FIFO_DEPTH, 16, byte entries in the FIFO; must be a power of 2 and at least 2.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  8  byte to transmit.
- data_valid  input  1  data_in is valid this cycle.
- data_ready  output  1  FIFO can accept a byte; equals not full.
- tx  output  1  serial line out, registered.
- busy  output  1  high while the FIFO is non-empty or a frame is in progress.
- tx_done  output  1  one-cycle pulse on the last cycle of each stop bit.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the byte being serialized.

Behaviour:
- Reset: tx=1, busy=0, tx_done=0, data_ready=1, fifo_count=0. FIFO pointers cleared, serializer in IDLE.
- Reset mid-frame: the frame is aborted, tx returns high on the cycle after rst is sampled, and all queued bytes are discarded.
- Push: occurs on any edge where data_valid and data_ready are both high. A push while full is impossible because data_ready is low; data_in is ignored in that case.
- FIFO: wrap-around read and write pointers with an extra MSB for full/empty detection. data_ready is registered or derived so that a pop and a push in the same cycle, with the FIFO full, does not assert data_ready until the following cycle.
- Pop: the serializer pops only in IDLE with the FIFO non-empty, or at the end of STOP with the FIFO non-empty.
- Simultaneous push and pop: allowed when the FIFO is not full; fifo_count stays unchanged.
- Serializer FSM states:
  - IDLE: tx=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right. After bit index 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the last cycle, pulse tx_done. Then either pop and go to START (FIFO non-empty), or go to IDLE.
- Bit timing: a down-counter is reloaded with CLKS_PER_BIT-1 at each bit start. Every bit lasts exactly CLKS_PER_BIT cycles, so a frame is exactly 10*CLKS_PER_BIT cycles.
- Back-to-back frames: there are no idle cycles between the stop bit of byte k and the start bit of byte k+1.
- Latency: a byte pushed at edge N, with the FIFO empty and the serializer in IDLE, drives tx low starting at edge N+2.
- busy: rises in the cycle after the first push and falls in the cycle after the final tx_done, provided nothing is queued.
- The input byte is latched at push. Later changes to data_in never affect queued bytes.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless noted):
- Single byte: push 0x55 into the idle block. tx low at push+2 cycles, then bit sequence 0,1,0,1,0,1,0,1,0,1 with 4 cycles per bit; tx_done pulses once after 40 cycles; busy then drops.
- Back-to-back: push 0xA3, 0x0F, 0xFF on consecutive cycles. Three frames of exactly 40 cycles each with no idle gap; the receiver-model decodes 0xA3, 0x0F, 0xFF in order; tx_done pulses 3 times.
- Full FIFO: hold data_valid high with 0x01..0x08. Expect:
  - the first byte is popped at once;
  - data_ready goes low when fifo_count=4;
  - it is re-asserted one cycle after each pop;
  - the serial output is 0x01..0x08 with no loss or duplication.
- Reset mid-frame: push 0xC6, assert rst during data bit 3. tx=1 on the next cycle, fifo_count=0, busy=0, no tx_done; a subsequent push of 0x3C transmits cleanly.
- Simultaneous push/pop: with 2 bytes queued, push exactly on the STOP-end pop cycle. fifo_count stays 2 and the byte order is preserved.
- Default timing: CLKS_PER_BIT=868, push 0x00. Start bit and all data bits low for 9*868 cycles, then stop bit high for 868 cycles.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, LSB first, idle-high line) fed by a small synchronous byte FIFO.
// The serializer drains the FIFO back-to-back; tx, busy, tx_done and data_ready are all registered.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   PTR_ONE    = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_r;
    logic [AW:0]   rd_ptr_r;
    logic [AW:0]   count_r;
    logic          data_ready_r;

    state_t        state_r;
    logic [CW-1:0] baud_cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic          tx_r;
    logic          busy_r;
    logic          tx_done_r;

    logic          push_s;
    logic          pop_s;
    logic          empty_s;
    logic          bit_end_s;
    logic [AW:0]   wr_ptr_next_s;
    logic [AW:0]   rd_ptr_next_s;
    logic          full_next_s;
    logic          busy_next_s;

    // Handshake, pop decision and next-pointer arithmetic.
    always_comb begin
        push_s    = data_valid & data_ready_r;
        empty_s   = (wr_ptr_r == rd_ptr_r);
        bit_end_s = (baud_cnt_r == {CW{1'b0}});

        case (state_r)
            ST_IDLE: pop_s = ~empty_s;
            ST_STOP: pop_s = bit_end_s & ~empty_s;
            default: pop_s = 1'b0;
        endcase

        if (push_s) begin
            wr_ptr_next_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end

        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end

        // Extra pointer MSB distinguishes full from empty when the index bits match.
        full_next_s = (wr_ptr_next_s[AW] != rd_ptr_next_s[AW]) &&
                      (wr_ptr_next_s[AW-1:0] == rd_ptr_next_s[AW-1:0]);

        // Any non-IDLE state keeps busy up through the tx_done cycle, since tx lags state by one.
        busy_next_s = (wr_ptr_next_s != rd_ptr_next_s) | pop_s | (state_r != ST_IDLE);
    end

    // FIFO storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= data_in;
        end
    end

    // FIFO pointers plus registered occupancy and ready flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r     <= {(AW+1){1'b0}};
            rd_ptr_r     <= {(AW+1){1'b0}};
            count_r      <= {(AW+1){1'b0}};
            data_ready_r <= 1'b1;
        end else begin
            wr_ptr_r     <= wr_ptr_next_s;
            rd_ptr_r     <= rd_ptr_next_s;
            count_r      <= wr_ptr_next_s - rd_ptr_next_s;
            data_ready_r <= ~full_next_s;
        end
    end

    // Serializer FSM; tx is registered from the current state, so the line trails the state by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= {CW{1'b0}};
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            tx_done_r  <= 1'b0;
        end else begin
            tx_done_r <= 1'b0;
            busy_r    <= busy_next_s;
            case (state_r)
                ST_IDLE: begin
                    tx_r <= 1'b1;
                    if (pop_s) begin
                        shift_r    <= mem_r[rd_ptr_r[AW-1:0]];
                        baud_cnt_r <= BIT_RELOAD;
                        state_r    <= ST_START;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_START: begin
                    tx_r <= 1'b0;
                    if (bit_end_s) begin
                        baud_cnt_r <= BIT_RELOAD;
                        bit_idx_r  <= 3'd0;
                        state_r    <= ST_DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r - CNT_ONE;
                    end
                end
                ST_DATA: begin
                    tx_r <= shift_r[0];
                    if (bit_end_s) begin
                        shift_r    <= {1'b0, shift_r[7:1]};
                        baud_cnt_r <= BIT_RELOAD;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r - CNT_ONE;
                    end
                end
                ST_STOP: begin
                    tx_r <= 1'b1;
                    if (bit_end_s) begin
                        tx_done_r <= 1'b1;
                        if (pop_s) begin
                            shift_r    <= mem_r[rd_ptr_r[AW-1:0]];
                            baud_cnt_r <= BIT_RELOAD;
                            state_r    <= ST_START;
                        end else begin
                            state_r    <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_ready = data_ready_r;
    assign tx         = tx_r;
    assign busy       = busy_r;
    assign tx_done    = tx_done_r;
    assign fifo_count = count_r;

endmodule
